// File: rtl/sdnet_gen_pkg.sv
// Shared definitions for the SDNet test-traffic transmitter.
//   - state_e    : frame generator FSM states
//   - header constants (MAC addresses, EtherType) and their byte offsets
//   - frame length clamp limits and clamp_len() helper
package sdnet_gen_pkg;

  localparam int LEN_W  = 14;  // frame_len width in bytes
  localparam int BEAT_W = 11;  // enough for ceil(9600 / 8) = 1200 beats

  localparam logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_MAC   = 48'h000A_3500_0001;
  localparam logic [15:0] ETHERTYPE = 16'h88B5;

  localparam logic [LEN_W-1:0] MIN_LEN = 14'd60;
  localparam logic [LEN_W-1:0] MAX_LEN = 14'd9600;

  // First byte offset of each header field; the destination MAC starts at 0.
  localparam int SRC_OFF     = 6;
  localparam int ETYPE_OFF   = 12;
  localparam int SEQ_OFF     = 14;
  localparam int PAYLOAD_OFF = 18;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP,
    DONE
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < MIN_LEN) return MIN_LEN;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

endpackage

// File: rtl/sdnet_tx_beat_builder.sv
// Combinational builder for one 64-bit beat of a test frame.
//   beat_idx  : index of the beat within the frame (0 = first)
//   seq_num   : sequence number written into bytes 14..17
//   frame_len : already-clamped frame length in bytes (FCS excluded)
//   tdata     : byte k on bits [8k+7:8k]; bytes past the frame end are zero
//   tkeep     : byte-valid mask; partial only on the last beat
//   tlast     : this is the final beat of the frame
module sdnet_tx_beat_builder
  import sdnet_gen_pkg::*;
(
  input  logic [BEAT_W-1:0] beat_idx,
  input  logic [31:0]       seq_num,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [63:0]       tdata,
  output logic [7:0]        tkeep,
  output logic              tlast
);

  logic [BEAT_W-1:0] last_idx;
  logic [2:0]        rem;
  int                n;
  logic [7:0]        byte_v;

  assign last_idx = BEAT_W'((frame_len - LEN_W'(1)) >> 3);
  assign rem      = frame_len[2:0];
  assign tlast    = (beat_idx == last_idx);
  assign tkeep    = (tlast && rem != 3'd0) ? 8'((9'd1 << rem) - 9'd1) : 8'hFF;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    tdata  = '0;
    n      = 0;
    byte_v = '0;
    for (int k = 0; k < 8; k++) begin
      n = int'({beat_idx, 3'(k)});
      // Header fields are big-endian: the field's first byte is its MSB.
      if (n >= int'(frame_len))  byte_v = 8'h00;
      else if (n < SRC_OFF)      byte_v = 8'(DST_MAC   >> (8 * (SRC_OFF - 1 - n)));
      else if (n < ETYPE_OFF)    byte_v = 8'(SRC_MAC   >> (8 * (ETYPE_OFF - 1 - n)));
      else if (n < SEQ_OFF)      byte_v = 8'(ETHERTYPE >> (8 * (SEQ_OFF - 1 - n)));
      else if (n < PAYLOAD_OFF)  byte_v = 8'(seq_num   >> (8 * (PAYLOAD_OFF - 1 - n)));
      else                       byte_v = 8'(n - PAYLOAD_OFF);
      tdata[8*k +: 8] = byte_v;
    end
  end

endmodule

// File: rtl/sdnet_tx_frame_gen.sv
// Ethernet test-frame generator driving a 64-bit AXI4-Stream master.
//   clk, reset_n       : datapath clock, asynchronous active-low reset
//   enable             : level; a rising edge starts a run, low ends it after the current frame
//   frame_len          : frame length in bytes, clamped to [MIN_LEN, MAX_LEN], latched per frame
//   ifg_cycles         : idle cycles between frames, latched per frame
//   num_frames         : frames per run (0 = continuous), latched per run
//   m_axis_*           : AXI4-Stream master (tdata/tkeep/tlast/tvalid out, tready in)
//   frames_sent        : frames completed in the current run
//   busy               : FSM not in IDLE
//   done               : one-cycle pulse when a finite run completes
module sdnet_tx_frame_gen
  import sdnet_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [7:0]        ifg_cycles,
  input  logic [31:0]       num_frames,
  output logic [63:0]       m_axis_tdata,
  output logic [7:0]        m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       frames_sent,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic              en_s_q, en_d_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        ifg_q, ifg_d;
  logic [7:0]        gap_q, gap_d;
  logic [BEAT_W-1:0] idx_q, idx_d;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       frames_q, frames_d;
  logic [31:0]       total_q, total_d;
  logic [63:0]       tdata_q, tdata_d;
  logic [7:0]        tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              en_rise;
  logic              start_frame, load_beat, stop_out;
  logic [63:0]       bld_tdata;
  logic [7:0]        bld_tkeep;
  logic              bld_tlast;

  // enable is registered once before edge detection, which gives the
  // two-edge start latency and keeps the FSM off the raw input.
  assign en_rise = en_s_q & ~en_d_q;

  // The builder always looks at the next-cycle beat, so its result can be
  // loaded straight into the output registers.
  sdnet_tx_beat_builder u_builder (
    .beat_idx  (idx_d),
    .seq_num   (seq_d),
    .frame_len (len_d),
    .tdata     (bld_tdata),
    .tkeep     (bld_tkeep),
    .tlast     (bld_tlast)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ifg_d       = ifg_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    frames_d    = frames_q;
    total_d     = total_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    start_frame = 1'b0;
    load_beat   = 1'b0;
    stop_out    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          seq_d       = '0;
          frames_d    = '0;
          total_d     = num_frames;
          start_frame = 1'b1;
        end
      end
      FRAME: begin
        if (tvalid_q && m_axis_tready) begin
          if (!tlast_q) begin
            idx_d     = idx_q + BEAT_W'(1);
            load_beat = 1'b1;
          end else begin
            frames_d = frames_q + 32'd1;
            seq_d    = seq_q + 32'd1;
            if (total_q != '0 && frames_d == total_q) begin
              state_d  = DONE;
              stop_out = 1'b1;
            end else if (!en_s_q) begin
              state_d  = IDLE;
              stop_out = 1'b1;
            end else if (ifg_q == 8'd0) begin
              start_frame = 1'b1;
            end else begin
              state_d  = GAP;
              gap_d    = ifg_q;
              stop_out = 1'b1;
            end
          end
        end
      end
      GAP: begin
        // gap_q counts the idle cycles still to be shown, including this one.
        if (gap_q <= 8'd1) begin
          if (!en_s_q) state_d = IDLE;
          else         start_frame = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d   = FRAME;
      len_d     = clamp_len(frame_len);
      ifg_d     = ifg_cycles;
      idx_d     = '0;
      load_beat = 1'b1;
    end

    if (load_beat) begin
      tdata_d  = bld_tdata;
      tkeep_d  = bld_tkeep;
      tlast_d  = bld_tlast;
      tvalid_d = 1'b1;
    end

    if (stop_out) begin
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
      tvalid_d = 1'b0;
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      en_s_q   <= 1'b0;
      en_d_q   <= 1'b0;
      len_q    <= MIN_LEN;
      ifg_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      frames_q <= '0;
      total_q  <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      en_s_q   <= enable;
      en_d_q   <= en_s_q;
      len_q    <= len_d;
      ifg_q    <= ifg_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      frames_q <= frames_d;
      total_q  <= total_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frames_sent   = frames_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sdnet_tx_frame_gen.sv
// Self-checking bench for sdnet_tx_frame_gen. Expected frames come from a
// byte-level model of the frame layout; outputs are sampled on the falling
// edge and inputs are driven there too.
`timescale 1ns/1ps
module tb_sdnet_tx_frame_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] frame_len = 14'd60;
  logic [7:0]  ifg_cycles = 8'd0;
  logic [31:0] num_frames = 32'd1;
  logic        tready = 1'b1;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic [31:0] frames_sent;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  sdnet_tx_frame_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .frame_len     (frame_len),
    .ifg_cycles    (ifg_cycles),
    .num_frames    (num_frames),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .frames_sent   (frames_sent),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input int req);
    if (req < 60) return 60;
    if (req > 9600) return 9600;
    return req;
  endfunction

  function automatic logic [7:0] ref_byte(input int n, input logic [31:0] seq);
    logic [47:0] dst = 48'hFFFF_FFFF_FFFF;
    logic [47:0] src = 48'h000A_3500_0001;
    logic [15:0] et  = 16'h88B5;
    if (n < 6)  return dst[8*(5-n) +: 8];
    if (n < 12) return src[8*(11-n) +: 8];
    if (n < 14) return et[8*(13-n) +: 8];
    if (n < 18) return seq[8*(17-n) +: 8];
    return 8'((n - 18) % 256);
  endfunction

  // Receives one frame. Counts tvalid-low cycles before its first beat,
  // checks AXIS hold while stalled, and optionally drops enable at a beat.
  task automatic recv_frame(input string tag, input int req_len, input logic [31:0] seq,
                            input bit bp, input int drop_at, input int exp_idle);
    int          len = ref_len(req_len);
    int          nb = (len + 7) / 8;
    int          beat = 0;
    int          idle = 0;
    int          guard = 0;
    bit          stalled = 1'b0;
    logic [63:0] pd = '0;
    logic [7:0]  pk = '0;
    logic        pl = 1'b0;
    logic [63:0] ed, m64;
    logic [7:0]  ek;
    while (beat < nb && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (stalled)
        check($sformatf("%s_hold", tag),
              96'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
              96'({1'b1, pl, pk, pd}));
      tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!m_axis_tvalid && beat == 0) idle++;
      if (m_axis_tvalid && tready) begin
        ed = '0;
        ek = '0;
        m64 = '0;
        for (int k = 0; k < 8; k++) begin
          if (beat * 8 + k < len) begin
            ed[8*k +: 8]  = ref_byte(beat * 8 + k, seq);
            ek[k]         = 1'b1;
            m64[8*k +: 8] = 8'hFF;
          end
        end
        check($sformatf("%s_data_b%0d", tag, beat), 96'(m_axis_tdata & m64), 96'(ed));
        check($sformatf("%s_keep_b%0d", tag, beat), 96'(m_axis_tkeep), 96'(ek));
        check($sformatf("%s_last_b%0d", tag, beat), 96'(m_axis_tlast), 96'(beat == nb - 1));
        if (beat == drop_at) enable = 1'b0;
        beat++;
      end
      stalled = m_axis_tvalid && !tready;
      pd = m_axis_tdata;
      pk = m_axis_tkeep;
      pl = m_axis_tlast;
    end
    check($sformatf("%s_beats", tag), 96'(beat), 96'(nb));
    if (exp_idle >= 0) check($sformatf("%s_idle", tag), 96'(idle), 96'(exp_idle));
  endtask

  // Full finite run: start on a fresh enable edge, receive nf frames, then
  // check the done pulse and return to IDLE.
  task automatic run_finite(input string tag, input int req_len, input int nf,
                            input int ifg, input bit bp);
    @(negedge clk);
    frame_len  = 14'(req_len);
    ifg_cycles = 8'(ifg);
    num_frames = 32'(nf);
    enable     = 1'b1;
    for (int f = 0; f < nf; f++)
      recv_frame($sformatf("%s_f%0d", tag, f), req_len, 32'(f), bp, -1, (f == 0) ? 1 : ifg);
    tready = 1'b1;
    @(negedge clk);
    check($sformatf("%s_done_hi", tag), 96'({done, busy, m_axis_tvalid}), 96'({1'b1, 1'b1, 1'b0}));
    check($sformatf("%s_sent", tag), 96'(frames_sent), 96'(nf));
    @(negedge clk);
    check($sformatf("%s_done_lo", tag), 96'({done, busy, m_axis_tvalid}), 96'(0));
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int valid_seen;
  int done_seen;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_out", 96'({m_axis_tvalid, m_axis_tlast, done, busy, m_axis_tkeep, m_axis_tdata}), 96'(0));
    check("reset_sent", 96'(frames_sent), 96'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Minimum frame, exact-size+1 frame, and an undersize request.
    run_finite("len60", 60, 1, 0, 1'b0);
    run_finite("len61", 61, 1, 0, 1'b0);
    run_finite("len10", 10, 1, 0, 1'b0);
    run_finite("len_big", 16000, 1, 0, 1'b0);

    // Backpressure over jumbo-ish frames, then random runs.
    run_finite("bp1500", 1500, 2, 2, 1'b1);
    for (int r = 0; r < 3; r++)
      run_finite($sformatf("rand%0d", r), int'($urandom_range(1, 3000)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 5)), 1'b1);

    // Three frames with a four-cycle gap.
    run_finite("ifg4", 64, 3, 4, 1'b0);

    // Continuous run; enable dropped in the second frame.
    @(negedge clk);
    frame_len  = 14'd200;
    ifg_cycles = 8'd1;
    num_frames = 32'd0;
    enable     = 1'b1;
    recv_frame("cont_f0", 200, 32'd0, 1'b0, -1, 1);
    recv_frame("cont_f1", 200, 32'd1, 1'b0, 3, 1);
    tready = 1'b1;
    valid_seen = 0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_axis_tvalid) valid_seen++;
      if (done) done_seen++;
    end
    check("cont_no_more_beats", 96'(valid_seen), 96'(0));
    check("cont_no_done", 96'(done_seen), 96'(0));
    check("cont_idle", 96'({busy, frames_sent}), 96'({1'b0, 32'd2}));

    // Reset in the middle of a frame.
    @(negedge clk);
    frame_len  = 14'd300;
    ifg_cycles = 8'd0;
    num_frames = 32'd0;
    enable     = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_valid", 96'(m_axis_tvalid), 96'(1));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out", 96'({m_axis_tvalid, m_axis_tlast, done, busy, m_axis_tkeep, m_axis_tdata}), 96'(0));
    check("mid_rst_sent", 96'(frames_sent), 96'(0));
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_quiet", 96'({m_axis_tvalid, busy}), 96'(0));
    enable = 1'b1;
    recv_frame("post_rst", 300, 32'd0, 1'b0, 2, 1);
    tready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_end", 96'({m_axis_tvalid, busy, frames_sent}), 96'({1'b0, 1'b0, 32'd1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
